// File: rtl/mcyc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control unit for the mips core, with a bounded mem_ack wait.
// Optional feature: define OVERFLOW_FLAG_EN to write the addi overflow bit to the flag register in WB.
module mcyc_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       gpr_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic [2:0] alu_op,
  output logic       ext_op,
  output logic       dm_re,
  output logic       dm_we,
  output logic       flag_we,
  output logic       flag_wd,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_J, I_JAL, I_JR, I_ADDU, I_SUBU, I_SLT, I_ADDI,
    I_ADDIU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_BAD
  } instr_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          ovf_q, ovf_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;
  instr_t        instr;

  logic       ir_we_c, pc_we_c, gpr_we_c, alu_src_c, ext_op_c;
  logic       dm_re_c, dm_we_c, flag_we_c, flag_wd_c;
  logic [1:0] npc_sel_c, reg_dst_c, wd_sel_c;
  logic [2:0] alu_op_c;

  always_comb begin
    instr = I_BAD;
    case (op)
      6'h00: begin
        case (funct)
          6'h00:   instr = I_NOP;
          6'h08:   instr = I_JR;
          6'h21:   instr = I_ADDU;
          6'h23:   instr = I_SUBU;
          6'h2a:   instr = I_SLT;
          default: instr = I_BAD;
        endcase
      end
      6'h02:   instr = I_J;
      6'h03:   instr = I_JAL;
      6'h04:   instr = I_BEQ;
      6'h08:   instr = I_ADDI;
      6'h09:   instr = I_ADDIU;
      6'h0d:   instr = I_ORI;
      6'h0f:   instr = I_LUI;
      6'h23:   instr = I_LW;
      6'h2b:   instr = I_SW;
      default: instr = I_BAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    npc_sel_c = 2'd0;
    gpr_we_c  = 1'b0;
    reg_dst_c = 2'd0;
    wd_sel_c  = 2'd0;
    alu_src_c = 1'b0;
    alu_op_c  = ALU_ADD;
    ext_op_c  = 1'b0;
    dm_re_c   = 1'b0;
    dm_we_c   = 1'b0;
    flag_we_c = 1'b0;
    flag_wd_c = 1'b0;

    case (state_q)
      S_IF: begin
        ir_we_c = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        state_d = S_EX;
        case (instr)
          I_NOP: begin
            pc_we_c = 1'b1;
            state_d = S_IF;
          end
          I_J: begin
            pc_we_c   = 1'b1;
            npc_sel_c = 2'd2;
            state_d   = S_IF;
          end
          I_JAL: begin
            pc_we_c   = 1'b1;
            npc_sel_c = 2'd2;
            gpr_we_c  = 1'b1;
            reg_dst_c = 2'd2;
            wd_sel_c  = 2'd2;
            state_d   = S_IF;
          end
          I_JR: begin
            pc_we_c   = 1'b1;
            npc_sel_c = 2'd3;
            state_d   = S_IF;
          end
          I_BAD: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        ovf_d     = overflow;
        alu_src_c = instr inside {I_ADDI, I_ADDIU, I_ORI, I_LUI, I_LW, I_SW};
        ext_op_c  = instr inside {I_ADDI, I_ADDIU, I_LW, I_SW, I_BEQ};
        case (instr)
          I_SUBU, I_BEQ: alu_op_c = ALU_SUB;
          I_ORI:         alu_op_c = ALU_OR;
          I_SLT:         alu_op_c = ALU_SLT;
          I_LUI:         alu_op_c = ALU_LUI;
          default:       alu_op_c = ALU_ADD;
        endcase
        if (instr == I_BEQ) begin
          pc_we_c   = 1'b1;
          npc_sel_c = zero ? 2'd1 : 2'd0;
          state_d   = S_IF;
        end else if (instr == I_LW || instr == I_SW) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dm_re_c = (instr == I_LW);
        dm_we_c = (instr == I_SW);
        if (mem_ack) begin
          if (instr == I_SW) begin
            pc_we_c = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else begin
          if (wait_q != CW'(MEM_TIMEOUT)) wait_d = wait_q + 1'b1;
          // This no-ack cycle is the MEM_TIMEOUT-th one: give up on the bus.
          if (wait_q == CW'(MEM_TIMEOUT - 1)) begin
            bus_err_d = 1'b1;
            state_d   = S_HALT;
          end
        end
      end
      S_WB: begin
        gpr_we_c  = 1'b1;
        pc_we_c   = 1'b1;
        reg_dst_c = (op == 6'h00) ? 2'd1 : 2'd0;
        wd_sel_c  = (instr == I_LW) ? 2'd1 : 2'd0;
`ifdef OVERFLOW_FLAG_EN
        flag_we_c = (instr == I_ADDI);
        flag_wd_c = (instr == I_ADDI) & ovf_q;
`endif
        state_d   = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        illegal_d = 1'b1;
        state_d   = S_HALT;
      end
    endcase
  end

`ifndef OVERFLOW_FLAG_EN
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

  // Outputs are gated by rst so nothing (not even ir_we in IF) is asserted during reset.
  assign ir_we   = rst & ir_we_c;
  assign pc_we   = rst & pc_we_c;
  assign npc_sel = rst ? npc_sel_c : 2'd0;
  assign gpr_we  = rst & gpr_we_c;
  assign reg_dst = rst ? reg_dst_c : 2'd0;
  assign wd_sel  = rst ? wd_sel_c : 2'd0;
  assign alu_src = rst & alu_src_c;
  assign alu_op  = rst ? alu_op_c : 3'd0;
  assign ext_op  = rst & ext_op_c;
  assign dm_re   = rst & dm_re_c;
  assign dm_we   = rst & dm_we_c;
  assign flag_we = rst & flag_we_c;
  assign flag_wd = rst & flag_wd_c;
  assign state   = rst ? state_q : 3'd0;
  assign illegal = rst & illegal_q;
  assign bus_err = rst & bus_err_q;

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Bench for mcyc_ctrl: a table-driven per-instruction cycle model feeds an expected queue
// that a negedge monitor compares against every control output.
module tb_mcyc_ctrl;

  localparam int TO = 15;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       gpr_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       dm_re;
    logic       dm_we;
    logic       flag_we;
    logic       flag_wd;
    logic [2:0] state;
    logic       illegal;
    logic       bus_err;
  } ctl_t;

  localparam int W = $bits(ctl_t);

  // cls: 0 = finishes in ID, 1 = beq, 2 = ALU with WB, 3 = lw, 4 = sw, 5 = illegal
  typedef struct packed {
    logic [2:0] cls;
    logic [1:0] npc;
    logic       link;
    logic [2:0] aop;
    logic       asrc;
    logic       ext;
    logic       rtype;
    logic       addi;
  } info_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, overflow = 1'b0, mem_ack = 1'b0;
  logic       ir_we, pc_we, gpr_we, alu_src, ext_op, dm_re, dm_we, flag_we, flag_wd, illegal, bus_err;
  logic [1:0] npc_sel, reg_dst, wd_sel;
  logic [2:0] alu_op, state;

  mcyc_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
    .mem_ack(mem_ack), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .gpr_we(gpr_we),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op),
    .dm_re(dm_re), .dm_we(dm_we), .flag_we(flag_we), .flag_wd(flag_wd), .state(state),
    .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           budget = 0;
  ctl_t         act;

  assign act = {ir_we, pc_we, npc_sel, gpr_we, reg_dst, wd_sel, alu_src, alu_op, ext_op,
                dm_re, dm_we, flag_we, flag_wd, state, illegal, bus_err};

  // Monitor: every clock the DUT presents a full control word; pop and compare.
  always @(negedge clk) begin
    logic [W-1:0] e;
    string        t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got ctl=%h expected ctl=%h", t, act, e);
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic info_t lookup(input logic [5:0] o, input logic [5:0] f);
    info_t k;
    k = '0;
    k.cls = 3'd5;
    case (o)
      6'h00: begin
        k.rtype = 1'b1;
        case (f)
          6'h00: k.cls = 3'd0;
          6'h08: begin k.cls = 3'd0; k.npc = 2'd3; end
          6'h21: begin k.cls = 3'd2; k.aop = 3'd0; end
          6'h23: begin k.cls = 3'd2; k.aop = 3'd1; end
          6'h2a: begin k.cls = 3'd2; k.aop = 3'd3; end
          default: k.cls = 3'd5;
        endcase
      end
      6'h02: begin k.cls = 3'd0; k.npc = 2'd2; end
      6'h03: begin k.cls = 3'd0; k.npc = 2'd2; k.link = 1'b1; end
      6'h04: begin k.cls = 3'd1; k.aop = 3'd1; k.ext = 1'b1; end
      6'h08: begin k.cls = 3'd2; k.aop = 3'd0; k.asrc = 1'b1; k.ext = 1'b1; k.addi = 1'b1; end
      6'h09: begin k.cls = 3'd2; k.aop = 3'd0; k.asrc = 1'b1; k.ext = 1'b1; end
      6'h0d: begin k.cls = 3'd2; k.aop = 3'd2; k.asrc = 1'b1; end
      6'h0f: begin k.cls = 3'd2; k.aop = 3'd4; k.asrc = 1'b1; end
      6'h23: begin k.cls = 3'd3; k.aop = 3'd0; k.asrc = 1'b1; k.ext = 1'b1; end
      6'h2b: begin k.cls = 3'd4; k.aop = 3'd0; k.asrc = 1'b1; k.ext = 1'b1; end
      default: k.cls = 3'd5;
    endcase
    return k;
  endfunction

  task automatic step(input ctl_t e, input logic [5:0] o, input logic [5:0] f, input string tg,
                      input logic a, input logic z, input logic v);
    if (budget > 0) begin
      budget--;
      @(posedge clk);
      #1;
      rst = 1'b1; op = o; funct = f; mem_ack = a; zero = z; overflow = v;
      exp_q.push_back(e);
      tag_q.push_back($sformatf("%s op=%02h f=%02h", tg, o, f));
    end
  endtask

  task automatic reset_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0; op = 6'($urandom); funct = 6'($urandom);
      mem_ack = rb(); zero = rb(); overflow = rb();
      exp_q.push_back('0);
      tag_q.push_back("reset");
    end
  endtask

  task automatic halt_cycles(input logic [5:0] o, input logic [5:0] f, input logic ill, input logic be);
    ctl_t c;
    for (int i = 0; i < 3; i++) begin
      c = '0; c.state = 3'd7; c.illegal = ill; c.bus_err = be;
      step(c, o, f, "HALT", rb(), rb(), rb());
    end
  endtask

  // waits < 0 means mem_ack never arrives.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int waits, input int max_cyc);
    ctl_t  c;
    info_t k;
    logic  z, v, ovf_ex;
    int    nw;
    k = lookup(o, f);
    budget = max_cyc;
    c = '0; c.ir_we = 1'b1;
    step(c, o, f, "IF", rb(), rb(), rb());
    c = '0; c.state = 3'd1;
    if (k.cls == 3'd0) begin
      c.pc_we = 1'b1; c.npc_sel = k.npc;
      if (k.link) begin c.gpr_we = 1'b1; c.reg_dst = 2'd2; c.wd_sel = 2'd2; end
      step(c, o, f, "ID", rb(), rb(), rb());
    end else if (k.cls == 3'd5) begin
      step(c, o, f, "ID", rb(), rb(), rb());
      halt_cycles(o, f, 1'b1, 1'b0);
    end else begin
      step(c, o, f, "ID", rb(), rb(), rb());
      z = rb(); v = rb(); ovf_ex = v;
      c = '0; c.state = 3'd2; c.alu_src = k.asrc; c.alu_op = k.aop; c.ext_op = k.ext;
      if (k.cls == 3'd1) begin c.pc_we = 1'b1; c.npc_sel = z ? 2'd1 : 2'd0; end
      step(c, o, f, "EX", rb(), z, v);
      if (k.cls == 3'd3 || k.cls == 3'd4) begin
        nw = (waits < 0) ? TO : waits;
        c = '0; c.state = 3'd3; c.dm_re = (k.cls == 3'd3); c.dm_we = (k.cls == 3'd4);
        for (int i = 0; i < nw; i++) step(c, o, f, "MEM_wait", 1'b0, rb(), rb());
        if (waits < 0) halt_cycles(o, f, 1'b0, 1'b1);
        else begin
          c.pc_we = (k.cls == 3'd4);
          step(c, o, f, "MEM_ack", 1'b1, rb(), rb());
        end
      end
      if ((k.cls == 3'd2 || k.cls == 3'd3) && waits >= 0) begin
        c = '0; c.state = 3'd4; c.gpr_we = 1'b1; c.pc_we = 1'b1;
        c.reg_dst = k.rtype ? 2'd1 : 2'd0;
        c.wd_sel = (k.cls == 3'd3) ? 2'd1 : 2'd0;
`ifdef OVERFLOW_FLAG_EN
        c.flag_we = k.addi; c.flag_wd = k.addi & ovf_ex;
`endif
        step(c, o, f, "WB", rb(), rb(), rb());
      end
    end
  endtask

  logic [11:0] legal [13];

  initial begin
    logic [5:0] o, f;
    int         idx;
    legal = '{{6'h00, 6'h00}, {6'h00, 6'h08}, {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h2a},
              {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h04, 6'h00}, {6'h08, 6'h00}, {6'h09, 6'h00},
              {6'h0d, 6'h00}, {6'h0f, 6'h00}, {6'h23, 6'h00}};

    reset_pulse(3);
    // Directed cases, including the zero-wait and longest-legal-wait memory accesses.
    run_instr(6'h00, 6'h21, 0, 100);
    run_instr(6'h23, 6'h04, 3, 100);
    run_instr(6'h2b, 6'h08, 0, 100);
    run_instr(6'h04, 6'h02, 0, 100);
    run_instr(6'h03, 6'h08, 0, 100);
    run_instr(6'h08, 6'h24, 0, 100);
    run_instr(6'h23, 6'h10, TO - 1, 100);
    run_instr(6'h2b, 6'h11, TO - 1, 100);

    for (int n = 0; n < 150; n++) begin
      idx = $urandom_range(0, 13);
      if (idx == 13) begin o = 6'h2b; f = 6'($urandom); end
      else begin
        o = legal[idx][11:6];
        f = (o == 6'h00) ? legal[idx][5:0] : 6'($urandom);
      end
      run_instr(o, f, $urandom_range(0, TO - 1), 100);
    end

    run_instr(6'h2b, 6'h00, -1, 100);
    reset_pulse(2);
    run_instr(6'h3f, 6'h00, 0, 100);
    reset_pulse(2);
    run_instr(6'h00, 6'h3f, 0, 100);
    reset_pulse(2);
    run_instr(6'h23, 6'h00, -1, 100);
    reset_pulse(1);
    // Abort an addu just after it enters EX; no WB may follow.
    run_instr(6'h00, 6'h21, 0, 2);
    reset_pulse(2);
    run_instr(6'h08, 6'h00, 0, 100);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
